btb_assoc: RTL
==============

Name: btb_assoc

Overview:
- Banked, set-associative branch target buffer; successor to the direct-mapped banked BTB in the fetch/branch-prediction stage.
- Predicts the target and type for every slot of a fetch block in the same cycle (asynchronous read).
- Each bank is WAYS-way associative with not-recently-used (NRU) replacement.
- Each entry carries a 2-bit hysteresis counter: repeated not-taken resolutions evict stale entries. A flush port clears all entries in one cycle.

Parameters:
- ENTRIES, 128, total entries across all banks and ways.
- BANKS, FETCH_WIDTH, banks (one per fetch slot); power of two.
- WAYS, 2, ways per set; power of two, >=1.
- TAG_WIDTH, 12, stored tag bits.
- Derived (localparam): SETS = ENTRIES/(BANKS*WAYS), power of two; IDX_WIDTH = clog2(SETS); BANK_BITS = clog2(BANKS), 0 when BANKS=1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- pc  in  CPU_ADDR_BITS  fetch-block PC, BANKS*4-byte aligned
- pred_hit  out  BANKS  per-slot hit
- pred_targs  out  CPU_ADDR_BITS x BANKS  per-slot predicted target
- pred_types  out  2 x BANKS  per-slot branch type
- flush  in  1  invalidate all entries
- update_val  in  1  resolved-branch update strobe
- update_pc  in  CPU_ADDR_BITS  PC of the resolved branch
- update_targ  in  CPU_ADDR_BITS  resolved target
- update_type  in  2  resolved branch type
- update_taken  in  1  resolved direction
- update_evict  out  1  registered pulse: the previous cycle's allocation replaced a valid entry

Behaviour:
- Address split (4-byte instructions):
  - bank = addr[BANK_BITS+1:2]
  - idx = addr[IDX_WIDTH+BANK_BITS+1:BANK_BITS+2]
  - tag = the next TAG_WIDTH bits above idx.
  - Prediction uses pc's idx/tag in every bank; the pc bank bits are ignored.
- Entry fields: val, tag, targ, btype, ctr[1:0]. Each set in each bank also holds one NRU bit per way.
- Read is combinational, per bank i:
  - pred_hit[i] = OR over ways of (val && tag match).
  - pred_targs[i] and pred_types[i] come from the hitting way.
  - On a miss they are '0. Pred_hit does not depend on ctr.
- At most one way per set ever matches a tag; guaranteed because allocation happens only on a lookup miss.
- Reads never change state. An update becomes visible to reads on the cycle after its clock edge; there is no same-cycle bypass.
- Update, on a clock edge with update_val=1, operating on bank/set/tag of update_pc:
  - Hit, taken: ctr saturates up (max 3); targ and btype are overwritten; the way's NRU bit is set.
  - Hit, not-taken: if ctr==1, clear val (eviction); otherwise ctr decrements (min 1). NRU is unchanged.
  - Miss, taken: allocate. Victim is the lowest-index invalid way; if all ways are valid, the lowest-index way with NRU=0. Write val=1, tag, targ, btype, ctr=2, and set the victim's NRU bit.
  - Miss, not-taken: no change.
- NRU maintenance: when setting an NRU bit would make all WAYS bits 1, clear every other way's bit in that set.
- update_evict is registered: it is 1 for exactly the cycle after an allocation whose victim had val=1, else 0. A hit-not-taken invalidation does not raise it.
- flush=1 at a clock edge:
  - Clears every val and NRU bit; tag, targ and ctr may keep stale values.
  - flush takes priority over a coincident update, which is dropped; update_evict is 0 on the next cycle.
- Reset (rst=0): asynchronously clears all val, NRU, ctr, tag, targ and btype fields, and update_evict.
  - Consequently pred_hit = '0, pred_targs = '0 and pred_types = '0 while rst is low, including mid-operation.
  - Updates are ignored while rst is low. Operation resumes on the first clock edge after deassertion.
- WAYS=1 degenerates to direct-mapped with hysteresis; the victim is always way 0.

Test Plan (ENTRIES=128, BANKS=2, WAYS=2, TAG_WIDTH=12, so idx=addr[7:3] and tag=addr[19:8]):
- Reset, then pc=0x1000 -> pred_hit=2'b00, targs=0, types=0; update_evict=0.
- Update taken pc=0x1004, targ=0x2000, type=1; next cycle pc=0x1000 -> pred_hit=2'b10, pred_targs[1]=0x2000, pred_types[1]=1; update_evict=0.
- Allocate taken 0x1004, then 0x2004 (same set/bank), then 0x3004. The 0x3004 allocation evicts 0x1004 (NRU bits cleared to 2'b10, way0 victim) and update_evict=1 for one cycle. Afterwards pc=0x2000 and pc=0x3000 hit bank 1; pc=0x1000 misses.
- Hysteresis: allocate 0x1004 (ctr=2). First not-taken update -> still hits (ctr=1). Second not-taken update -> pred_hit[1]=0, with update_evict=0. A third taken update re-allocates it and it hits again.
- flush=1 in the same cycle as a taken update to 0x1008 -> next cycle every tested pc misses, including pc=0x1008, and update_evict=0.
- Drive rst=0 between clock edges with valid entries present -> pred_hit=0 immediately. After rst=1, a taken update to 0x1004 hits on the following cycle.

Source files
------------

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and resolve-side update bundle for the associative BTB.
// master drives pc/flush/update_*; slave returns predictions and evict pulse.
interface btb_assoc_if #(
  parameter int ADDR_W = 32,
  parameter int BANKS  = 2
);
  logic [ADDR_W-1:0]             pc;
  logic [BANKS-1:0]              pred_hit;
  logic [BANKS-1:0][ADDR_W-1:0]  pred_targs;
  logic [BANKS-1:0][1:0]         pred_types;
  logic                          flush;
  logic                          update_val;
  logic [ADDR_W-1:0]             update_pc;
  logic [ADDR_W-1:0]             update_targ;
  logic [1:0]                    update_type;
  logic                          update_taken;
  logic                          update_evict;

  modport master (
    output pc, flush, update_val, update_pc,
    output update_targ, update_type, update_taken,
    input  pred_hit, pred_targs, pred_types, update_evict
  );

  modport slave (
    input  pc, flush, update_val, update_pc,
    input  update_targ, update_type, update_taken,
    output pred_hit, pred_targs, pred_types, update_evict
  );
endinterface

// File: rtl/btb_assoc.sv
// Banked set-associative BTB with NRU replacement and 2-bit hysteresis.
// Ports: clk, rst (async active-low), bus (btb_assoc_if.slave).
module btb_assoc #(
  parameter int CPU_ADDR_BITS = 32,
  parameter int FETCH_WIDTH   = 2,
  parameter int ENTRIES       = 128,
  parameter int BANKS         = FETCH_WIDTH,
  parameter int WAYS          = 2,
  parameter int TAG_WIDTH     = 12
) (
  input logic        clk,
  input logic        rst,
  btb_assoc_if.slave bus
);
  localparam int A         = CPU_ADDR_BITS;
  localparam int SETS      = ENTRIES / (BANKS * WAYS);
  localparam int IDX_WIDTH = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int BANK_BITS = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int BW        = (BANKS > 1) ? BANK_BITS : 1;
  localparam int WB        = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_LSB   = IDX_WIDTH + BANK_BITS + 2;

  logic [WAYS-1:0]      val_q  [BANKS][SETS];
  logic [WAYS-1:0]      nru_q  [BANKS][SETS];
  logic [TAG_WIDTH-1:0] tag_q  [BANKS][SETS][WAYS];
  logic [A-1:0]         targ_q [BANKS][SETS][WAYS];
  logic [1:0]           type_q [BANKS][SETS][WAYS];
  logic [1:0]           ctr_q  [BANKS][SETS][WAYS];
  logic                 evict_q;

  function automatic logic [BW-1:0] bank_of(input logic [A-1:0] a);
    logic [A-1:0] s;
    s = a >> 2;
    return (BANKS > 1) ? s[BW-1:0] : '0;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] idx_of(input logic [A-1:0] a);
    logic [A-1:0] s;
    s = a >> (BANK_BITS + 2);
    return (SETS > 1) ? s[IDX_WIDTH-1:0] : '0;
  endfunction

  function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [A-1:0] a);
    logic [A-1:0] s;
    s = a >> TAG_LSB;
    return s[TAG_WIDTH-1:0];
  endfunction

  // Set the way's NRU bit; once every way is marked, keep only this one.
  function automatic logic [WAYS-1:0] nru_set(
    input logic [WAYS-1:0] n,
    input logic [WB-1:0]   w
  );
    logic [WAYS-1:0] r;
    r = n;
    r[w] = 1'b1;
    if (&r) begin
      r = '0;
      r[w] = 1'b1;
    end
    return r;
  endfunction

  logic [IDX_WIDTH-1:0] ri;
  logic [TAG_WIDTH-1:0] rt;

  assign ri = idx_of(bus.pc);
  assign rt = tag_of(bus.pc);

  always_comb begin
    bus.pred_hit   = '0;
    bus.pred_targs = '0;
    bus.pred_types = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (val_q[b][ri][w] && tag_q[b][ri][w] == rt) begin
          bus.pred_hit[b]   = 1'b1;
          bus.pred_targs[b] = targ_q[b][ri][w];
          bus.pred_types[b] = type_q[b][ri][w];
        end
      end
    end
  end

  logic [BW-1:0]        ub;
  logic [IDX_WIDTH-1:0] ui;
  logic [TAG_WIDTH-1:0] ut;
  logic                 uhit;
  logic [WB-1:0]        hway;
  logic                 vfound;
  logic [WB-1:0]        vway;

  assign ub = bank_of(bus.update_pc);
  assign ui = idx_of(bus.update_pc);
  assign ut = tag_of(bus.update_pc);

  always_comb begin
    uhit   = 1'b0;
    hway   = '0;
    vfound = 1'b0;
    vway   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!uhit && val_q[ub][ui][w] &&
          tag_q[ub][ui][w] == ut) begin
        uhit = 1'b1;
        hway = WB'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!vfound && !val_q[ub][ui][w]) begin
        vfound = 1'b1;
        vway   = WB'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!vfound && !nru_q[ub][ui][w]) begin
        vfound = 1'b1;
        vway   = WB'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evict_q <= 1'b0;
      for (int b = 0; b < BANKS; b++) begin
        for (int s = 0; s < SETS; s++) begin
          val_q[b][s] <= '0;
          nru_q[b][s] <= '0;
          for (int w = 0; w < WAYS; w++) begin
            tag_q[b][s][w]  <= '0;
            targ_q[b][s][w] <= '0;
            type_q[b][s][w] <= '0;
            ctr_q[b][s][w]  <= '0;
          end
        end
      end
    end else begin
      evict_q <= 1'b0;
      if (bus.flush) begin
        for (int b = 0; b < BANKS; b++) begin
          for (int s = 0; s < SETS; s++) begin
            val_q[b][s] <= '0;
            nru_q[b][s] <= '0;
          end
        end
      end else if (bus.update_val) begin
        if (uhit) begin
          if (bus.update_taken) begin
            if (ctr_q[ub][ui][hway] != 2'd3)
              ctr_q[ub][ui][hway] <= ctr_q[ub][ui][hway] + 2'd1;
            targ_q[ub][ui][hway] <= bus.update_targ;
            type_q[ub][ui][hway] <= bus.update_type;
            nru_q[ub][ui] <= nru_set(nru_q[ub][ui], hway);
          end else if (ctr_q[ub][ui][hway] == 2'd1) begin
            val_q[ub][ui][hway] <= 1'b0;
          end else if (ctr_q[ub][ui][hway] > 2'd1) begin
            ctr_q[ub][ui][hway] <= ctr_q[ub][ui][hway] - 2'd1;
          end
        end else if (bus.update_taken) begin
          val_q[ub][ui][vway]  <= 1'b1;
          tag_q[ub][ui][vway]  <= ut;
          targ_q[ub][ui][vway] <= bus.update_targ;
          type_q[ub][ui][vway] <= bus.update_type;
          ctr_q[ub][ui][vway]  <= 2'd2;
          nru_q[ub][ui] <= nru_set(nru_q[ub][ui], vway);
          evict_q <= val_q[ub][ui][vway];
        end
      end
    end
  end

  assign bus.update_evict = evict_q;
endmodule
